// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: FSM state codes and SPI mode 0 constants.
package spi_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_LOAD  = LOAD,
        ST_SHIFT = SHIFT
    } spi_state_e;

    // Mode 0: SCK idles low, data sampled on the leading (rising) edge.
    localparam logic SPI_CPOL  = 1'b0;
    localparam logic SPI_CPHA  = 1'b0;
    localparam logic SSN_IDLE  = 1'b1;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small first-word-fall-through FIFO for received SPI frames.
module spi_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              valid_o,
    output logic              full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              do_pop;
    logic              do_push;

    assign valid_o = (count_reg != '0);
    assign full_o  = (count_reg == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = valid_o ? mem_reg[rd_ptr_reg] : '0;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode 0 target with oversampled, synchronized SCK/SSN/MOSI and valid/ready frame ports.
// Define SPI_TARGET_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO instead of a single holding register.
module spi_target
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              spi_sck_i,
    input  logic              spi_ssn_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              rx_ovf_o,
    output logic              tx_unf_o
);

    localparam int         CNT_W    = $clog2(DATA_W);
    localparam logic [2:0] PIN_IDLE = {SSN_IDLE, SPI_CPOL, 1'b0};

    if (DATA_W < 2 || SYNC_STAGES < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("spi_target: DATA_W>=2, SYNC_STAGES>=1, FIFO_DEPTH power of two >=2");
    end

    // Pins travel together through the synchronizer as {ssn, sck, mosi}.
    logic [2:0] pin_sync_reg [SYNC_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] stage_in;
            if (gi == 0) begin : g_head
                assign stage_in = {spi_ssn_i, spi_sck_i, spi_mosi_i};
            end else begin : g_tail
                assign stage_in = pin_sync_reg[gi-1];
            end
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    pin_sync_reg[gi] <= PIN_IDLE;
                end else begin
                    pin_sync_reg[gi] <= stage_in;
                end
            end
        end
    endgenerate

    logic              ssn_s, sck_s, mosi_s;
    logic              sck_prev_reg, ssn_prev_reg;
    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] rx_sr_reg;
    logic [DATA_W-1:0] tx_sr_reg;
    logic              tx_unf_reg;
    logic              rx_ovf_reg;
    logic              sck_rise, sck_fall, ssn_fall;
    logic              frame_done, tx_load, store_blocked;
    logic [DATA_W-1:0] frame_data;

    assign {ssn_s, sck_s, mosi_s} = pin_sync_reg[SYNC_STAGES-1];

    assign sck_rise   = sck_s && !sck_prev_reg;
    assign sck_fall   = !sck_s && sck_prev_reg;
    assign ssn_fall   = !ssn_s && ssn_prev_reg;
    assign frame_done = (state_reg == SHIFT) && !ssn_s && sck_rise &&
                        (bit_cnt_reg == CNT_W'(DATA_W - 1));
    assign frame_data = {rx_sr_reg[DATA_W-2:0], mosi_s};
    assign tx_load    = (state_reg == LOAD) || frame_done;

    assign tx_ready_o  = tx_load && tx_valid_i;
    assign tx_unf_o    = tx_unf_reg;
    assign rx_ovf_o    = rx_ovf_reg;
    assign spi_miso_oe = (state_reg != IDLE);
    assign spi_miso_o  = (state_reg != IDLE) && tx_sr_reg[DATA_W-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sck_prev_reg <= SPI_CPOL;
            ssn_prev_reg <= SSN_IDLE;
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            rx_sr_reg    <= '0;
            tx_sr_reg    <= '0;
            tx_unf_reg   <= 1'b0;
        end else begin
            sck_prev_reg <= sck_s;
            ssn_prev_reg <= ssn_s;
            tx_unf_reg   <= tx_load && !tx_valid_i;

            // The falling edge right after a reload (count back at 0) must not
            // shift, or the fresh MSB would be lost before the initiator sees it.
            if (tx_load) begin
                tx_sr_reg <= tx_valid_i ? tx_data_i : '1;
            end else if (state_reg == SHIFT && sck_fall && bit_cnt_reg != '0) begin
                tx_sr_reg <= {tx_sr_reg[DATA_W-2:0], 1'b1};
            end

            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= '0;
                    if (ssn_fall) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    state_reg <= ssn_s ? IDLE : SHIFT;
                end
                SHIFT: begin
                    if (ssn_s) begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                    end else if (sck_rise) begin
                        rx_sr_reg   <= frame_data;
                        bit_cnt_reg <= frame_done ? '0 : bit_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SPI_TARGET_RX_FIFO_EN
    logic fifo_full;

    spi_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (frame_done),
        .push_data_i (frame_data),
        .pop_i       (rx_ready_i),
        .head_o      (rx_data_o),
        .valid_o     (rx_valid_o),
        .full_o      (fifo_full)
    );

    assign store_blocked = fifo_full && !rx_ready_i;
`else
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else if (frame_done && !store_blocked) begin
            rx_data_reg  <= frame_data;
            rx_valid_reg <= 1'b1;
        end else if (rx_valid_reg && rx_ready_i) begin
            rx_valid_reg <= 1'b0;
        end
    end

    assign rx_data_o     = rx_data_reg;
    assign rx_valid_o    = rx_valid_reg;
    assign store_blocked = rx_valid_reg && !rx_ready_i;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_ovf_reg <= 1'b0;
        end else begin
            rx_ovf_reg <= frame_done && store_blocked;
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI initiator drives frames at clk/8, a queue model checks the rx port every cycle.
`timescale 1ns/1ps
module tb_spi_target;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 4;
`ifdef SPI_TARGET_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif
    // Synchronizer stages plus the one cycle from detected edge to rx_valid_o.
    localparam int LAT = SYNC_STAGES + 1;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              spi_sck_i, spi_ssn_i, spi_mosi_i;
    logic              spi_miso_o, spi_miso_oe;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o, rx_ready_i;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i, tx_ready_o;
    logic              rx_ovf_o, tx_unf_o;

    always #5 clk = ~clk;

    spi_target #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .spi_sck_i   (spi_sck_i),
        .spi_ssn_i   (spi_ssn_i),
        .spi_mosi_i  (spi_mosi_i),
        .spi_miso_o  (spi_miso_o),
        .spi_miso_oe (spi_miso_oe),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .rx_ovf_o    (rx_ovf_o),
        .tx_unf_o    (tx_unf_o)
    );

    typedef struct {
        logic [7:0]  data;
        int unsigned due;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    pend_t       pend_q[$];
    logic [7:0]  model_q[$];
    logic [7:0]  got_q[$];
    int          unf_cnt = 0;
    int          rdy_cnt = 0;
    int          ovf_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] last_got();
        if (got_q.size() == 0) return 32'hDEAD;
        return {24'h0, got_q[$]};
    endfunction

    // Per-cycle model: each observation reflects the posedge just before it,
    // whose inputs are still on the pins (stimulus changes 1ns after negedge).
    initial begin : compare
        logic       prev_valid;
        logic [7:0] prev_data;
        logic       exp_ovf;
        pend_t      p;
        prev_valid = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                model_q.delete();
                pend_q.delete();
                prev_valid = 1'b0;
                check("rst_rx_valid", rx_valid_o, 0);
                check("rst_rx_ovf", rx_ovf_o, 0);
                check("rst_tx_unf", tx_unf_o, 0);
                check("rst_miso_oe", spi_miso_oe, 0);
            end else begin
                if (prev_valid && rx_ready_i) begin
                    got_q.push_back(prev_data);
                    $display("rx frame 0x%02h accepted at cycle %0d", prev_data, cyc);
                end
                if (model_q.size() > 0 && rx_ready_i) void'(model_q.pop_front());
                exp_ovf = 1'b0;
                if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    p = pend_q.pop_front();
                    if (model_q.size() < CAP) model_q.push_back(p.data);
                    else exp_ovf = 1'b1;
                end
                check("rx_valid", rx_valid_o, model_q.size() > 0);
                if (model_q.size() > 0) check("rx_data", rx_data_o, model_q[0]);
                check("rx_ovf", rx_ovf_o, exp_ovf);
                ovf_cnt += rx_ovf_o;
                unf_cnt += tx_unf_o;
                rdy_cnt += tx_ready_o;
                prev_valid = rx_valid_o;
                prev_data  = rx_data_o;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic ssn_low();
        spi_ssn_i = 1'b0;
        wait_clks(4);
    endtask

    task automatic ssn_high();
        wait_clks(4);
        spi_ssn_i = 1'b1;
        wait_clks(8);
        check("idle_miso_oe", spi_miso_oe, 0);
        check("idle_miso", spi_miso_o, 0);
    endtask

    // Mode 0 initiator, SCK = clk/8; next_tx/next_valid are applied after the first rising edge.
    task automatic send_bits(input logic [7:0] d, input int nbits, input logic [7:0] next_tx,
                             input logic next_valid, output logic [7:0] miso_byte);
        miso_byte = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = d[7-i];
            wait_clks(4);
            spi_sck_i = 1'b1;
            miso_byte = {miso_byte[6:0], spi_miso_o};
            check("sel_miso_oe", spi_miso_oe, 1);
            if (i == 0) begin
                tx_data_i  = next_tx;
                tx_valid_i = next_valid;
            end
            if (i == 7) pend_q.push_back('{data: d, due: cyc + LAT});
            wait_clks(4);
            spi_sck_i = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] mb, mb2;
        logic [7:0] vals [5];
        logic [7:0] exp_q[$];
        int         u0, r0, o0, g0;

        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        reset_i    = 1'b1;
        spi_sck_i  = 1'b0;
        spi_ssn_i  = 1'b1;
        spi_mosi_i = 1'b0;
        rx_ready_i = 1'b1;
        tx_data_i  = '0;
        tx_valid_i = 1'b0;
        wait_clks(3);
        check("reset_rx_data", rx_data_o, 0);
        check("reset_rx_valid", rx_valid_o, 0);
        check("reset_miso", spi_miso_o, 0);
        check("reset_tx_ready", tx_ready_o, 0);
        reset_i = 1'b0;
        wait_clks(3);

        // 0xA5 in, 0x3C out; tx loaded at frame start and again at completion.
        tx_data_i = 8'h3C; tx_valid_i = 1'b1;
        u0 = unf_cnt; r0 = rdy_cnt;
        ssn_low();
        send_bits(8'hA5, 8, 8'h3C, 1'b1, mb);
        ssn_high();
        check("a5_miso", mb, 8'h3C);
        check("a5_rx", last_got(), 8'hA5);
        check("a5_tx_ready", rdy_cnt - r0, 2);
        check("a5_tx_unf", unf_cnt - u0, 0);

        // Back-to-back frames under one select, distinct tx words per frame.
        tx_data_i = 8'h96;
        ssn_low();
        send_bits(8'h12, 8, 8'h69, 1'b1, mb);
        send_bits(8'h34, 8, 8'h69, 1'b1, mb2);
        ssn_high();
        check("b2b_miso0", mb, 8'h96);
        check("b2b_miso1", mb2, 8'h69);
        check("b2b_count", got_q.size(), 3);
        check("b2b_rx1", last_got(), 8'h34);

        // Underflow: nothing to send at frame start.
        tx_valid_i = 1'b0;
        u0 = unf_cnt; r0 = rdy_cnt;
        ssn_low();
        send_bits(8'hC7, 8, 8'h5E, 1'b1, mb);
        ssn_high();
        check("unf_miso", mb, 8'hFF);
        check("unf_pulses", unf_cnt - u0, 1);
        check("unf_tx_ready", rdy_cnt - r0, 1);

        // Overflow: consumer stalled, one frame more than storage holds.
        rx_ready_i = 1'b0;
        o0 = ovf_cnt;
        ssn_low();
        for (int k = 0; k <= CAP; k++) send_bits(vals[k], 8, 8'hA0, 1'b1, mb);
        ssn_high();
        check("ovf_pulses", ovf_cnt - o0, 1);
        check("ovf_held_valid", rx_valid_o, 1);
        check("ovf_held_data", rx_data_o, 8'h11);
        rx_ready_i = 1'b1;
        wait_clks(CAP + 4);

        // Select dropped after 3 bits: partial frame discarded.
        g0 = got_q.size();
        ssn_low();
        send_bits(8'hE0, 3, 8'hA1, 1'b1, mb);
        ssn_high();
        check("abort_no_rx", got_q.size(), g0);
        ssn_low();
        send_bits(8'h81, 8, 8'hA1, 1'b1, mb);
        ssn_high();
        check("abort_next_rx", last_got(), 8'h81);

        // Reset in the middle of a frame.
        ssn_low();
        send_bits(8'hF0, 5, 8'hA2, 1'b1, mb);
        reset_i = 1'b1;
        wait_clks(2);
        check("midrst_oe", spi_miso_oe, 0);
        check("midrst_miso", spi_miso_o, 0);
        check("midrst_rx_data", rx_data_o, 0);
        check("midrst_tx_ready", tx_ready_o, 0);
        spi_ssn_i = 1'b1;
        wait_clks(2);
        u0 = unf_cnt; o0 = ovf_cnt; g0 = got_q.size();
        reset_i = 1'b0;
        wait_clks(6);
        check("release_unf", unf_cnt - u0, 0);
        check("release_ovf", ovf_cnt - o0, 0);
        check("release_rx", got_q.size(), g0);
        ssn_low();
        send_bits(8'h5A, 8, 8'hA3, 1'b1, mb);
        ssn_high();
        check("post_rst_rx", last_got(), 8'h5A);

        // Whole accepted stream, hand-listed.
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'hC7, 8'h11};
`ifdef SPI_TARGET_RX_FIFO_EN
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
`endif
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h5A);
        check("stream_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("stream[%0d]", i), got_q[i], exp_q[i]);
        check("model_drained", model_q.size() + pend_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
